// File: rtl/cpu_pkg.sv
// Shared CPU constants used by the register file, the ALU and the control unit.
package cpu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned REG_ZERO = 0;
  localparam int unsigned WRCNT_W  = 16;

  typedef logic [DATA_W-1:0]  word_t;
  typedef logic [ADDR_W-1:0]  reg_idx_t;
  typedef logic [WRCNT_W-1:0] wr_count_t;

endpackage

// File: rtl/reg_file_if.sv
// Register-file port bundle: two combinational read ports, one write port and a debug read port.
interface reg_file_if #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
);

  logic [ADDR_W-1:0]           RSaddr_i;
  logic [ADDR_W-1:0]           RTaddr_i;
  logic [ADDR_W-1:0]           RDaddr_i;
  logic [DATA_W-1:0]           RDdata_i;
  logic                        RegWrite_i;
  logic [ADDR_W-1:0]           DBGaddr_i;
  logic [DATA_W-1:0]           RSdata_o;
  logic [DATA_W-1:0]           RTdata_o;
  logic [DATA_W-1:0]           DBGdata_o;
  logic [cpu_pkg::WRCNT_W-1:0] WrCount_o;

  modport master (
    output RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i, DBGaddr_i,
    input  RSdata_o, RTdata_o, DBGdata_o, WrCount_o
  );

  modport slave (
    input  RSaddr_i, RTaddr_i, RDaddr_i, RDdata_i, RegWrite_i, DBGaddr_i,
    output RSdata_o, RTdata_o, DBGdata_o, WrCount_o
  );

endinterface

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file: entry 0 reads zero, write-through bypass on both read
// ports, registered write-first debug port and a wrapping committed-write counter.
module reg_file #(
  parameter int unsigned DATA_W = cpu_pkg::DATA_W,
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input logic       clk_i,
  input logic       rst_i,
  reg_file_if.slave bus
);

  import cpu_pkg::*;

  localparam int unsigned       NREGS    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

  typedef logic [DATA_W-1:0] data_t;

  // Entry 0 has no storage; the array starts at index 1.
  data_t               regs_q [1:NREGS-1];
  data_t               regs_d [1:NREGS-1];
  data_t               dbg_q;
  data_t               dbg_d;
  logic [WRCNT_W-1:0]  wr_count_q;
  logic [WRCNT_W-1:0]  wr_count_d;
  logic                wr_commit;
  data_t               rs_data;
  data_t               rt_data;

  function automatic data_t read_entry(input data_t arr [1:NREGS-1],
                                       input logic [ADDR_W-1:0] idx);
    data_t r;
    r = '0;
    for (int unsigned i = 1; i < NREGS; i++) begin
      if (idx == ADDR_W'(i)) r = arr[i];
    end
    return r;
  endfunction

  assign wr_commit = !rst_i && bus.RegWrite_i && (bus.RDaddr_i != ZERO_IDX);

  always_comb begin
    rs_data = '0;
    if (!rst_i && (bus.RSaddr_i != ZERO_IDX)) begin
      if (wr_commit && (bus.RDaddr_i == bus.RSaddr_i)) rs_data = bus.RDdata_i;
      else                                              rs_data = read_entry(regs_q, bus.RSaddr_i);
    end
  end

  always_comb begin
    rt_data = '0;
    if (!rst_i && (bus.RTaddr_i != ZERO_IDX)) begin
      if (wr_commit && (bus.RDaddr_i == bus.RTaddr_i)) rt_data = bus.RDdata_i;
      else                                              rt_data = read_entry(regs_q, bus.RTaddr_i);
    end
  end

  // Debug read samples the post-write array so a same-edge write is visible (write-first).
  always_comb begin
    regs_d     = regs_q;
    wr_count_d = wr_count_q;
    if (wr_commit) begin
      for (int unsigned i = 1; i < NREGS; i++) begin
        if (bus.RDaddr_i == ADDR_W'(i)) regs_d[i] = bus.RDdata_i;
      end
      wr_count_d = wr_count_q + WRCNT_W'(1);
    end
    dbg_d = read_entry(regs_d, bus.DBGaddr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 1; i < NREGS; i++) regs_q[i] <= '0;
      dbg_q      <= '0;
      wr_count_q <= '0;
    end else begin
      for (int unsigned i = 1; i < NREGS; i++) regs_q[i] <= regs_d[i];
      dbg_q      <= dbg_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.RSdata_o  = rs_data;
  assign bus.RTdata_o  = rt_data;
  assign bus.DBGdata_o = dbg_q;
  assign bus.WrCount_o = wr_count_q;

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: expected values are queued as stimulus is driven and
// compared when the corresponding output is sampled.
module tb_reg_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) rf_if ();

  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (rf_if.slave)
  );

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t        sb [$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] mdl [32];
  logic [15:0] mdl_cnt;
  logic [31:0] mdl_dbg;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
      end
    end
  endtask

  // Expected combinational read for the inputs currently driven.
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (rst || a == 5'd0) return 32'h0;
    if (rf_if.RegWrite_i && rf_if.RDaddr_i != 5'd0 && rf_if.RDaddr_i == a) return rf_if.RDdata_i;
    return mdl[a];
  endfunction

  // Advance the model by one edge using the current inputs, then the DUT.
  task automatic clk_step();
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mdl_cnt = 16'h0;
      mdl_dbg = 32'h0;
    end else begin
      if (rf_if.RegWrite_i && rf_if.RDaddr_i != 5'd0) begin
        mdl[rf_if.RDaddr_i] = rf_if.RDdata_i;
        mdl_cnt             = mdl_cnt + 16'h1;
      end
      mdl_dbg = mdl[rf_if.DBGaddr_i];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input logic we, input logic [4:0] rd, input logic [31:0] d);
    rf_if.RegWrite_i = we;
    rf_if.RDaddr_i   = rd;
    rf_if.RDdata_i   = d;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    mdl_cnt = 16'h0;
    mdl_dbg = 32'h0;
    rst = 1'b1;
    rf_if.RSaddr_i  = '0;
    rf_if.RTaddr_i  = '0;
    rf_if.DBGaddr_i = '0;
    drive_write(1'b0, 5'd0, 32'h0);
    clk_step();
    clk_step();
    rst = 1'b0;

    // Post-reset sweep of every index on all three read paths.
    expect_val("wrcount_reset", 32'h0);
    check({16'h0, rf_if.WrCount_o});
    for (int i = 0; i < 32; i++) begin
      rf_if.RSaddr_i  = 5'(i);
      rf_if.RTaddr_i  = 5'(i);
      rf_if.DBGaddr_i = 5'(i);
      #1;
      expect_val("rs_reset", 32'h0);
      check(rf_if.RSdata_o);
      expect_val("rt_reset", 32'h0);
      check(rf_if.RTdata_o);
      clk_step();
      expect_val("dbg_reset", 32'h0);
      check(rf_if.DBGdata_o);
    end

    // Plain write then read next cycle.
    drive_write(1'b1, 5'd5, 32'hDEADBEEF);
    clk_step();
    drive_write(1'b0, 5'd0, 32'h0);
    rf_if.RSaddr_i = 5'd5;
    rf_if.RTaddr_i = 5'd5;
    #1;
    expect_val("rs_idx5", 32'hDEADBEEF);
    check(rf_if.RSdata_o);
    expect_val("rt_idx5", 32'hDEADBEEF);
    check(rf_if.RTdata_o);
    expect_val("wrcount_one", 32'h1);
    check({16'h0, rf_if.WrCount_o});

    // Write to index 0 is discarded and never bypassed.
    drive_write(1'b1, 5'd0, 32'h12345678);
    rf_if.RSaddr_i = 5'd0;
    rf_if.RTaddr_i = 5'd5;
    #1;
    expect_val("rs_zero_inflight", 32'h0);
    check(rf_if.RSdata_o);
    expect_val("rt_no_bypass_rd0", 32'hDEADBEEF);
    check(rf_if.RTdata_o);
    clk_step();
    drive_write(1'b0, 5'd0, 32'h0);
    #1;
    expect_val("rs_zero_after", 32'h0);
    check(rf_if.RSdata_o);
    expect_val("wrcount_rd0", 32'h1);
    check({16'h0, rf_if.WrCount_o});

    // Both ports bypass the in-flight write.
    drive_write(1'b1, 5'd7, 32'hA5A5A5A5);
    rf_if.RSaddr_i = 5'd7;
    rf_if.RTaddr_i = 5'd7;
    #1;
    expect_val("rs_bypass", 32'hA5A5A5A5);
    check(rf_if.RSdata_o);
    expect_val("rt_bypass", 32'hA5A5A5A5);
    check(rf_if.RTdata_o);
    clk_step();
    drive_write(1'b0, 5'd0, 32'h0);
    #1;
    expect_val("rs_idx7_stored", 32'hA5A5A5A5);
    check(rf_if.RSdata_o);

    // Only the matching port bypasses; debug sees the same-edge write.
    drive_write(1'b1, 5'd5, 32'h0BADF00D);
    rf_if.RSaddr_i  = 5'd7;
    rf_if.RTaddr_i  = 5'd5;
    rf_if.DBGaddr_i = 5'd5;
    #1;
    expect_val("rs_no_bypass", 32'hA5A5A5A5);
    check(rf_if.RSdata_o);
    expect_val("rt_single_bypass", 32'h0BADF00D);
    check(rf_if.RTdata_o);
    clk_step();
    expect_val("dbg_write_first", 32'h0BADF00D);
    check(rf_if.DBGdata_o);
    expect_val("wrcount_three", 32'h3);
    check({16'h0, rf_if.WrCount_o});

    // Reset dominates a coincident write and disables the bypass.
    rst = 1'b1;
    drive_write(1'b1, 5'd9, 32'h1);
    rf_if.RSaddr_i = 5'd9;
    rf_if.RTaddr_i = 5'd7;
    #1;
    expect_val("rs_in_reset", 32'h0);
    check(rf_if.RSdata_o);
    expect_val("rt_in_reset", 32'h0);
    check(rf_if.RTdata_o);
    clk_step();
    rst = 1'b0;
    drive_write(1'b0, 5'd0, 32'h0);
    rf_if.RSaddr_i  = 5'd9;
    rf_if.RTaddr_i  = 5'd5;
    rf_if.DBGaddr_i = 5'd7;
    #1;
    expect_val("rs_idx9_after_rst", 32'h0);
    check(rf_if.RSdata_o);
    expect_val("rt_idx5_after_rst", 32'h0);
    check(rf_if.RTdata_o);
    expect_val("wrcount_after_rst", 32'h0);
    check({16'h0, rf_if.WrCount_o});
    expect_val("dbg_after_rst", 32'h0);
    check(rf_if.DBGdata_o);
    clk_step();
    expect_val("dbg_idx7_after_rst", 32'h0);
    check(rf_if.DBGdata_o);

    // Drive the counter to 16'hFFFF, then wrap it.
    for (int i = 0; i < 65535; i++) begin
      drive_write(1'b1, 5'((i % 31) + 1), $urandom);
      clk_step();
    end
    drive_write(1'b0, 5'd0, 32'h0);
    rf_if.RSaddr_i = 5'd12;
    rf_if.RTaddr_i = 5'd31;
    #1;
    expect_val("wrcount_ffff", 32'h0000FFFF);
    check({16'h0, rf_if.WrCount_o});
    expect_val("rs_idx12_model", exp_rd(5'd12));
    check(rf_if.RSdata_o);
    expect_val("rt_idx31_model", exp_rd(5'd31));
    check(rf_if.RTdata_o);

    drive_write(1'b1, 5'd3, 32'h3);
    rf_if.DBGaddr_i = 5'd0;
    clk_step();
    drive_write(1'b0, 5'd0, 32'h0);
    rf_if.DBGaddr_i = 5'd3;
    #1;
    expect_val("wrcount_wrap", 32'h0);
    check({16'h0, rf_if.WrCount_o});
    expect_val("dbg_idx0", 32'h0);
    check(rf_if.DBGdata_o);
    clk_step();
    expect_val("dbg_idx3", 32'h3);
    check(rf_if.DBGdata_o);
    expect_val("dbg_idx3_model", mdl_dbg);
    check(rf_if.DBGdata_o);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
